vx_launch_ctrl: RTL and testbench
=================================

// Module: vx_launch_ctrl
// PURPOSE
//  Memory-mapped launch/status controller for the Vortex core, sitting between the host bus slave and
//  Vortex's clk/reset/busy pins. Replaces the single start/status register pair with a sequenced launch FSM:
//  reset-hold window, busy handshake, run-cycle counter, watchdog timeout, abort and a done/fault interrupt.
// PARAMETERS
//  ADDR_WIDTH    32      bus address width
//  BASE_ADDR     'hFFF0  byte address of register 0; registers at BASE_ADDR + 4*idx
//  RESET_CYCLES  8       cycles vx_reset is held after a start (>=1)
//  CNT_WIDTH     32      width of run-cycle counter and timeout register (<=32)
//  TIMEOUT_RST   0       reset value of TIMEOUT register (0 = watchdog disabled)
// PORTS
//  clk            in   1           single clock, all logic posedge
//  reset          in   1           synchronous, active-high
//  bus_req_valid  in   1           bus request strobe
//  bus_req_rw     in   1           0 = write, 1 = read
//  bus_req_addr   in   ADDR_WIDTH  byte address
//  bus_req_data   in   32          write data
//  bus_req_ready  out  1           constant 1; every valid request is accepted the cycle it is presented
//  bus_rsp_valid  out  1           read data valid, exactly one cycle after an accepted read
//  bus_rsp_data   out  32          read data
//  vx_reset       out  1           reset to Vortex, registered
//  vx_busy        in   1           busy from Vortex
//  irq            out  1           level interrupt, set on DONE or FAULT entry
// BEHAVIOUR
//  Registers (idx): 0 CTRL  W: [0] start, [1] abort, [2] irq_clr; reads return 0.
//   1 STATUS R: [0] active (WAIT|RUN), [1] done, [2] timeout, [3] irq, [6:4] state code, rest 0.
//   2 CYCLES R: run counter, zero-extended. 3 TIMEOUT RW: watchdog limit, zero-extended on read.
//   Writes to R-only or unmapped addresses are ignored. Unmapped reads return 0 and still respond.
//  Reset: state=IDLE, vx_reset=1, irq=0, CYCLES=0, TIMEOUT=TIMEOUT_RST, bus_rsp_valid=0, bus_rsp_data=0.
//  State codes: IDLE=0, HOLD=1, WAIT=2, RUN=3, DONE=4, FAULT=5.
//   IDLE : vx_reset=1. start -> HOLD.
//   HOLD : vx_reset=1. Hold counter loads RESET_CYCLES-1 on entry; at 0 -> WAIT.
//          vx_reset is high for exactly RESET_CYCLES cycles after the start write cycle.
//   WAIT : vx_reset=0. vx_busy=1 -> RUN.
//   RUN  : vx_reset=0. vx_busy=0 -> DONE.
//   DONE : vx_reset=0. Set done and irq. start -> HOLD.
//   FAULT: vx_reset=1. Set timeout and irq. start -> HOLD.
//  CYCLES: cleared on HOLD entry; +1 each cycle in WAIT and RUN; saturates at all-ones; frozen otherwise.
//  Watchdog: in WAIT or RUN, if TIMEOUT!=0 and CYCLES==TIMEOUT-1 on this cycle -> FAULT.
//   Watchdog takes priority over busy transitions in the same cycle.
//  start in HOLD/WAIT/RUN is ignored. abort in any state -> IDLE; done/timeout flags clear; irq unchanged.
//   abort wins over start in the same write.
//  done/timeout flags clear on HOLD entry. irq clears on irq_clr or start.
//   Setting wins over clearing in the same cycle.
//  Reads sample register state before that cycle's updates. bus_rsp_data holds its value when bus_rsp_valid=0.
//  A write to TIMEOUT takes effect for the next cycle's watchdog compare.
//  Synchronous reset mid-run returns everything to reset values in the next cycle; vx_reset is high that cycle.
// TESTING
//  1. reset; write CTRL=1; vx_busy high 3 cycles after vx_reset falls, low 10 cycles later
//     -> vx_reset high exactly 8 cycles; STATUS reads state 4 with done=1, irq=1; CYCLES=13.
//  2. TIMEOUT=20, start, hold vx_busy=1 forever
//     -> FAULT after CYCLES=20; vx_reset=1; STATUS[2]=1; irq=1.
//  3. start, then write CTRL=3 (abort+start) during RUN
//     -> state IDLE next cycle, vx_reset=1, no HOLD entry.
//  4. irq_clr written in the same cycle as DONE entry
//     -> irq=1. Then irq_clr alone -> irq=0.
//  5. read STATUS, read addr BASE+0x40, back-to-back
//     -> two rsp_valid pulses on consecutive cycles; second data=0; req_ready constantly 1.
//  6. assert reset while in RUN with CYCLES=500
//     -> next cycle: IDLE, CYCLES=0, irq=0, TIMEOUT=TIMEOUT_RST, vx_reset=1.

Source files
------------

// File: rtl/vx_launch_ctrl.sv
// vx_launch_ctrl: memory-mapped launch/status sequencer for the Vortex core (reset hold, busy handshake, cycle count, watchdog, irq)
module vx_launch_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'hFFF0,
  parameter int RESET_CYCLES = 8,
  parameter int CNT_WIDTH = 32,
  parameter logic [CNT_WIDTH-1:0] TIMEOUT_RST = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bus_req_valid,
  input  logic                  bus_req_rw,
  input  logic [ADDR_WIDTH-1:0] bus_req_addr,
  input  logic [31:0]           bus_req_data,
  output logic                  bus_req_ready,
  output logic                  bus_rsp_valid,
  output logic [31:0]           bus_rsp_data,
  output logic                  vx_reset,
  input  logic                  vx_busy,
  output logic                  irq
);
  localparam int HW = $clog2(RESET_CYCLES + 1);
  typedef enum logic [2:0] {IDLE = 3'd0, HOLD = 3'd1, WAIT = 3'd2, RUN = 3'd3, DONE = 3'd4, FAULT = 3'd5} state_t;
  state_t state, next;
  logic [HW-1:0] hold_cnt;
  logic [CNT_WIDTH-1:0] cycles, timeout;
  logic [3:0] sel;
  logic wr, rd, start, abort, irq_clr, active, wd, hold_entry, flag_entry;
  logic [31:0] rd_data;
  assign bus_req_ready = 1'b1;
  assign wr = bus_req_valid & ~bus_req_rw;
  assign rd = bus_req_valid & bus_req_rw;
  assign sel[0] = bus_req_addr == BASE_ADDR;
  assign sel[1] = bus_req_addr == ADDR_WIDTH'(BASE_ADDR + 4);
  assign sel[2] = bus_req_addr == ADDR_WIDTH'(BASE_ADDR + 8);
  assign sel[3] = bus_req_addr == ADDR_WIDTH'(BASE_ADDR + 12);
  assign start = wr & sel[0] & bus_req_data[0] & ~bus_req_data[1];
  assign abort = wr & sel[0] & bus_req_data[1];
  assign irq_clr = wr & sel[0] & bus_req_data[2];
  assign active = state == WAIT || state == RUN;
  assign wd = active && timeout != '0 && cycles == timeout - CNT_WIDTH'(1);
  assign hold_entry = next == HOLD && state != HOLD;
  assign flag_entry = (next == DONE || next == FAULT) && next != state;
  always_comb begin
    next = state;
    if (abort) next = IDLE;
    else if ((state == IDLE || state == DONE || state == FAULT) && start) next = HOLD;
    else if (state == HOLD && hold_cnt == '0) next = WAIT;
    else if (wd) next = FAULT;
    else if (state == WAIT && vx_busy) next = RUN;
    else if (state == RUN && !vx_busy) next = DONE;
  end
  always_comb begin
    rd_data = sel[1] ? {25'd0, state, irq, state == FAULT, state == DONE, active} :
              sel[2] ? 32'(cycles) :
              sel[3] ? 32'(timeout) : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      hold_cnt <= '0;
      cycles <= '0;
      timeout <= TIMEOUT_RST;
      irq <= 1'b0;
      vx_reset <= 1'b1;
      bus_rsp_valid <= 1'b0;
      bus_rsp_data <= '0;
    end else begin
      state <= next;
      hold_cnt <= hold_entry ? HW'(RESET_CYCLES - 1) : state == HOLD ? hold_cnt - HW'(1) : hold_cnt;
      cycles <= hold_entry ? '0 : (active && ~&cycles) ? cycles + CNT_WIDTH'(1) : cycles;
      if (wr && sel[3]) timeout <= bus_req_data[CNT_WIDTH-1:0];
      irq <= flag_entry | (irq & ~irq_clr & ~start);
      vx_reset <= next == IDLE || next == HOLD || next == FAULT;
      bus_rsp_valid <= rd;
      if (rd) bus_rsp_data <= rd_data;
    end
  end
endmodule

// File: tb/tb_vx_launch_ctrl.sv
// tb_vx_launch_ctrl: scoreboard bench for vx_launch_ctrl with directed launch, watchdog, abort, irq and reset scenarios
module tb_vx_launch_ctrl;
  localparam logic [31:0] BASE = 32'hFFF0;
  localparam logic [31:0] CTRL = BASE, STAT = BASE + 4, CYC = BASE + 8, TMO = BASE + 12;
  logic clk = 0, reset = 1, bus_req_valid = 0, bus_req_rw = 0, vx_busy = 0;
  logic [31:0] bus_req_addr = '0, bus_req_data = '0;
  logic bus_req_ready, bus_rsp_valid, vx_reset, irq;
  logic [31:0] bus_rsp_data;
  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_q[$];
  string nm_q[$];
  vx_launch_ctrl dut (
    .clk(clk), .reset(reset), .bus_req_valid(bus_req_valid), .bus_req_rw(bus_req_rw),
    .bus_req_addr(bus_req_addr), .bus_req_data(bus_req_data), .bus_req_ready(bus_req_ready),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_data(bus_rsp_data), .vx_reset(vx_reset),
    .vx_busy(vx_busy), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!reset) check("req_ready", 32'(bus_req_ready), 32'd1);
    if (bus_rsp_valid) begin
      if (exp_q.size() == 0) check("unexpected_rsp", bus_rsp_data, 32'hDEADBEEF ^ bus_rsp_data);
      else check(nm_q.pop_front(), bus_rsp_data, exp_q.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_req_valid = 1; bus_req_rw = 0; bus_req_addr = a; bus_req_data = d;
    tick();
    bus_req_valid = 0;
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
    bus_req_valid = 1; bus_req_rw = 1; bus_req_addr = a;
    exp_q.push_back(e); nm_q.push_back(nm);
    tick();
    bus_req_valid = 0;
  endtask
  task automatic wait_run(input string nm);
    int n = 0;
    while (vx_reset && n < 50) begin tick(); n++; end
    check({nm, "_reset_fall"}, 32'(vx_reset), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    tick();
    check("rst_vx_reset", 32'(vx_reset), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rsp_valid", 32'(bus_rsp_valid), 32'd0);
    check("rst_rsp_data", bus_rsp_data, 32'd0);
    tick();
    reset = 0;
    rd(STAT, 32'h0, "rst_status");
    rd(CYC, 32'd0, "rst_cycles");
    rd(TMO, 32'd0, "rst_timeout");
    rd(CTRL, 32'd0, "ctrl_read_zero");
    // launch: reset hold, busy handshake, done
    wr(CTRL, 32'h1);
    n = 0;
    while (vx_reset && n < 50) begin n++; tick(); end
    check("hold_len", 32'(n), 32'd8);
    tick(); tick();
    vx_busy = 1;
    repeat (10) tick();
    vx_busy = 0;
    tick();
    check("done_irq", 32'(irq), 32'd1);
    check("done_vx_reset", 32'(vx_reset), 32'd0);
    rd(STAT, 32'h4A, "done_status");
    rd(CYC, 32'd13, "done_cycles");
    // irq_clr coinciding with DONE entry
    wr(CTRL, 32'h1);
    check("start_clears_irq", 32'(irq), 32'd0);
    rd(STAT, 32'h10, "hold_status");
    wait_run("t4");
    vx_busy = 1;
    tick();
    vx_busy = 0;
    wr(CTRL, 32'h4);
    check("irq_set_wins", 32'(irq), 32'd1);
    wr(CTRL, 32'h4);
    check("irq_clr", 32'(irq), 32'd0);
    rd(CYC, 32'd2, "t4_cycles");
    // watchdog
    wr(TMO, 32'd20);
    rd(TMO, 32'd20, "timeout_rw");
    wr(CTRL, 32'h1);
    wait_run("t2");
    vx_busy = 1;
    n = 0;
    while (!vx_reset && n < 100) begin n++; tick(); end
    check("wd_len", 32'(n), 32'd20);
    check("fault_irq", 32'(irq), 32'd1);
    rd(STAT, 32'h5C, "fault_status");
    rd(CYC, 32'd20, "fault_cycles");
    vx_busy = 0;
    wr(CTRL, 32'h2);
    rd(STAT, 32'h08, "abort_keeps_irq");
    wr(TMO, 32'd0);
    wr(STAT, 32'hFF);
    wr(BASE + 32'h40, 32'h1);
    rd(STAT, 32'h08, "ignored_writes");
    // abort+start during RUN
    wr(CTRL, 32'h1);
    wait_run("t3");
    vx_busy = 1;
    tick(); tick();
    wr(CTRL, 32'h3);
    check("abort_vx_reset", 32'(vx_reset), 32'd1);
    rd(STAT, 32'h0, "abort_status");
    rd(CYC, 32'd3, "abort_cycles_frozen");
    vx_busy = 0;
    // back-to-back reads including unmapped
    rd(STAT, 32'h0, "b2b_status");
    check("b2b_first_valid", 32'(bus_rsp_valid), 32'd1);
    rd(BASE + 32'h40, 32'h0, "b2b_unmapped");
    check("b2b_second_valid", 32'(bus_rsp_valid), 32'd1);
    // synchronous reset mid-run
    wr(TMO, 32'd1000);
    wr(CTRL, 32'h1);
    wait_run("t6");
    vx_busy = 1;
    repeat (500) tick();
    rd(CYC, 32'd500, "pre_reset_cycles");
    reset = 1;
    tick();
    check("mid_rst_vx_reset", 32'(vx_reset), 32'd1);
    check("mid_rst_irq", 32'(irq), 32'd0);
    reset = 0;
    vx_busy = 0;
    rd(STAT, 32'h0, "mid_rst_status");
    rd(CYC, 32'd0, "mid_rst_cycles");
    rd(TMO, 32'd0, "mid_rst_timeout");
    tick(); tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
